pmc_gate_strobe_gen: RTL and testbench
======================================

PMC_GATE_STROBE_GEN -- requirements
Module: pmc_gate_strobe_gen

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the gate_len, strobe_delay and strobe_len fields.
REQ-002 Parameter RPT_WIDTH, default 8: width of repeat_cnt.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle request to run the sequence; honoured only in IDLE.
REQ-006 abort  input  1  synchronous stop; highest priority.
REQ-007 gate_len  input  CNT_WIDTH  gate-high cycles per iteration.
REQ-008 strobe_delay  input  CNT_WIDTH  low cycles between gate fall and strobe rise.
REQ-009 strobe_len  input  CNT_WIDTH  strobe-high cycles per iteration.
REQ-010 repeat_cnt  input  RPT_WIDTH  iterations minus one.
REQ-011 pmc_bus  interface  soc_pmc_bus.slave  drives gate and strobe to the pixel matrix controller.
REQ-012 busy  output  1  high while a sequence runs.
REQ-013 done  output  1  one-cycle pulse on normal completion.

Function
REQ-014 FSM states: IDLE, GATE, DELAY, STROBE, DONE.
REQ-015 In IDLE, start=1 with abort=0 latches gate_len, strobe_delay, strobe_len and repeat_cnt and loads the iteration counter; input changes during a run are ignored.
REQ-016 gate, strobe, busy and done are registered; start sampled at edge N gives busy=1 from cycle N+1.
REQ-017 Iteration order: GATE (gate=1 for gate_len cycles), DELAY (gate=strobe=0 for strobe_delay cycles), STROBE (strobe=1 for strobe_len cycles).
REQ-018 The first GATE cycle is cycle N+1; each phase follows the previous one with no idle cycle.
REQ-019 A phase with length 0 is skipped with zero cycles; an iteration with all three lengths 0 takes exactly one dead cycle (busy=1, gate=strobe=0).
REQ-020 gate and strobe are never high in the same cycle.
REQ-021 After STROBE, if iterations remain, the next GATE begins the following cycle; the total iteration count is repeat_cnt+1.
REQ-022 After the last iteration the FSM enters DONE for exactly one cycle: done=1, busy=0, gate=strobe=0; it then returns to IDLE.
REQ-023 start outside IDLE is ignored; start during the DONE cycle is ignored.
REQ-024 abort=1 in any state forces IDLE at the next edge: gate=strobe=busy=done=0 and no done pulse.
REQ-025 start=1 and abort=1 together in IDLE leave the FSM in IDLE.
REQ-026 Phase counters are CNT_WIDTH wide and count down to 1; a maximum value (2^CNT_WIDTH-1) yields exactly that many cycles, with no wrap.

Reset
REQ-027 rst_n=0 at an edge forces IDLE, gate=0, strobe=0, busy=0, done=0, and clears all counters and latched configuration.
REQ-028 Reset mid-sequence aborts it immediately, with no done pulse; the first start after rst_n returns to 1 is honoured.

Structure
REQ-029 The FSM state enum and the default CNT_WIDTH and RPT_WIDTH values belong in the shared SoC package as pmc_gen_state_t, PMC_CNT_WIDTH and PMC_RPT_WIDTH.
REQ-030 One sub-module, pmc_phase_counter, provides a loadable down-counter with a terminal-count flag, instantiated once and reloaded per phase.

Verification
REQ-031 gate_len=4, strobe_delay=2, strobe_len=3, repeat_cnt=0, start at cycle 0: gate high cycles 1-4, strobe high cycles 7-9, done=1 at cycle 10, busy high cycles 1-9.
REQ-032 Same lengths with repeat_cnt=2: three identical 9-cycle iterations back-to-back from cycle 1, with the second gate rising at cycle 10, and done at cycle 28.
REQ-033 gate_len=0, strobe_delay=0, strobe_len=5: strobe high cycles 1-5, gate never high, done at cycle 6; all lengths 0 with repeat_cnt=0: busy only at cycle 1, done at cycle 2.
REQ-034 abort at cycle 3 of REQ-031: all outputs 0 from cycle 4, no done; start at cycle 6 restarts with gate at cycle 7.
REQ-035 start pulses at cycles 2 and 10 during the REQ-031 run, with gate_len changed to 9 at cycle 2: the timing stays identical to REQ-031, and exactly one done pulse occurs.
REQ-036 rst_n low for cycle 5 of a run: all outputs 0 from cycle 6; start plus abort together in IDLE: busy stays 0.

Source files
------------

// File: rtl/soc_pkg.sv
// ============================================================================
// Module : soc_pkg
// Purpose: Shared SoC definitions for the pixel-matrix-controller gate/strobe
//          generator: default field widths and the generator FSM state type.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package soc_pkg;

  localparam int PMC_CNT_WIDTH = 16;
  localparam int PMC_RPT_WIDTH = 8;

  typedef enum logic [2:0] {
    PMC_IDLE   = 3'd0,
    PMC_GATE   = 3'd1,
    PMC_DELAY  = 3'd2,
    PMC_STROBE = 3'd3,
    PMC_DONE   = 3'd4
  } pmc_gen_state_t;

endpackage : soc_pkg

`default_nettype wire

// File: rtl/soc_pmc_bus.sv
// ============================================================================
// Module : soc_pmc_bus
// Purpose: Gate/strobe link to the pixel matrix controller.
// Ports  : gate   - pixel gate level
//          strobe - readout strobe level
//          slave modport drives both, master modport observes them.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface soc_pmc_bus;
  logic gate;
  logic strobe;

  modport slave  (output gate, output strobe);
  modport master (input  gate, input  strobe);
endinterface : soc_pmc_bus

`default_nettype wire

// File: rtl/pmc_phase_counter.sv
// ============================================================================
// Module : pmc_phase_counter
// Purpose: Loadable down-counter timing one generator phase. A load of L
//          makes tc_o high on the L-th cycle after the load (counts L..1).
// Ports  : clk, rst_n   - clock, synchronous active-low reset
//          clr_i        - synchronous clear (highest priority after reset)
//          load_i       - load load_val_i on this edge
//          load_val_i   - phase length
//          tc_o         - terminal count (value equals 1)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pmc_phase_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      // Stops at zero so an idle counter never wraps to all-ones.
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_WIDTH'(1));

endmodule : pmc_phase_counter

`default_nettype wire

// File: rtl/pmc_gate_strobe_gen.sv
// ============================================================================
// Module : pmc_gate_strobe_gen
// Purpose: Generates repeated GATE -> DELAY -> STROBE sequences for the pixel
//          matrix controller. Zero-length phases are skipped; an iteration
//          whose phases are all zero costs one dead cycle.
// Ports  : clk, rst_n    - clock, synchronous active-low reset
//          start, abort  - run request (IDLE only) / stop (highest priority)
//          gate_len      - gate-high cycles per iteration
//          strobe_delay  - low cycles between gate fall and strobe rise
//          strobe_len    - strobe-high cycles per iteration
//          repeat_cnt    - iterations minus one
//          pmc_bus       - gate/strobe to the pixel matrix controller
//          busy, done    - sequence running / one-cycle completion pulse
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pmc_gate_strobe_gen
  import soc_pkg::*;
#(
  parameter int CNT_WIDTH = PMC_CNT_WIDTH,
  parameter int RPT_WIDTH = PMC_RPT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] gate_len,
  input  logic [CNT_WIDTH-1:0] strobe_delay,
  input  logic [CNT_WIDTH-1:0] strobe_len,
  input  logic [RPT_WIDTH-1:0] repeat_cnt,
  soc_pmc_bus.slave            pmc_bus,
  output logic                 busy,
  output logic                 done
);

  typedef struct packed {
    logic                 found;
    pmc_gen_state_t       st;
    logic [CNT_WIDTH-1:0] len;
  } pick_t;

  // First phase at or after index 'from' (0=gate,1=delay,2=strobe,3=none)
  // with a non-zero length.
  function automatic pick_t pick_phase(input logic [1:0]           from,
                                       input logic [CNT_WIDTH-1:0] g,
                                       input logic [CNT_WIDTH-1:0] d,
                                       input logic [CNT_WIDTH-1:0] s);
    pick_t r;
    r.found = 1'b0;
    r.st    = PMC_IDLE;
    r.len   = '0;
    if ((from == 2'd0) && (g != '0)) begin
      r.found = 1'b1;
      r.st    = PMC_GATE;
      r.len   = g;
    end else if ((from <= 2'd1) && (d != '0)) begin
      r.found = 1'b1;
      r.st    = PMC_DELAY;
      r.len   = d;
    end else if ((from <= 2'd2) && (s != '0)) begin
      r.found = 1'b1;
      r.st    = PMC_STROBE;
      r.len   = s;
    end
    return r;
  endfunction

  // Entry point of a fresh iteration. An all-zero iteration is realised as a
  // single DELAY cycle, which keeps busy high with gate and strobe low.
  function automatic pick_t iter_start(input logic [CNT_WIDTH-1:0] g,
                                       input logic [CNT_WIDTH-1:0] d,
                                       input logic [CNT_WIDTH-1:0] s);
    pick_t r;
    r = pick_phase(2'd0, g, d, s);
    if (!r.found) begin
      r.found = 1'b1;
      r.st    = PMC_DELAY;
      r.len   = CNT_WIDTH'(1);
    end
    return r;
  endfunction

  pmc_gen_state_t       state_q, state_d;
  logic [CNT_WIDTH-1:0] gate_len_q, gate_len_d;
  logic [CNT_WIDTH-1:0] delay_q, delay_d;
  logic [CNT_WIDTH-1:0] strobe_len_q, strobe_len_d;
  logic [RPT_WIDTH-1:0] rpt_q, rpt_d;
  logic                 gate_q, strobe_q, busy_q, done_q;

  logic                 cnt_load;
  logic [CNT_WIDTH-1:0] cnt_load_val;
  logic                 cnt_tc;
  logic [1:0]           next_idx;
  pick_t                nxt;

  always_comb begin
    case (state_q)
      PMC_GATE:  next_idx = 2'd1;
      PMC_DELAY: next_idx = 2'd2;
      default:   next_idx = 2'd3;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    gate_len_d   = gate_len_q;
    delay_d      = delay_q;
    strobe_len_d = strobe_len_q;
    rpt_d        = rpt_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    nxt          = '0;

    if (abort) begin
      state_d = PMC_IDLE;
    end else begin
      case (state_q)
        PMC_IDLE: begin
          if (start) begin
            gate_len_d   = gate_len;
            delay_d      = strobe_delay;
            strobe_len_d = strobe_len;
            rpt_d        = repeat_cnt;
            nxt          = iter_start(gate_len, strobe_delay, strobe_len);
            state_d      = nxt.st;
            cnt_load     = 1'b1;
            cnt_load_val = nxt.len;
          end
        end

        PMC_GATE, PMC_DELAY, PMC_STROBE: begin
          if (cnt_tc) begin
            nxt = pick_phase(next_idx, gate_len_q, delay_q, strobe_len_q);
            if (nxt.found) begin
              state_d      = nxt.st;
              cnt_load     = 1'b1;
              cnt_load_val = nxt.len;
            end else if (rpt_q != '0) begin
              rpt_d        = rpt_q - RPT_WIDTH'(1);
              nxt          = iter_start(gate_len_q, delay_q, strobe_len_q);
              state_d      = nxt.st;
              cnt_load     = 1'b1;
              cnt_load_val = nxt.len;
            end else begin
              state_d = PMC_DONE;
            end
          end
        end

        PMC_DONE: state_d = PMC_IDLE;

        default:  state_d = PMC_IDLE;
      endcase
    end
  end

  pmc_phase_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .tc_o       (cnt_tc)
  );

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= PMC_IDLE;
      gate_len_q   <= '0;
      delay_q      <= '0;
      strobe_len_q <= '0;
      rpt_q        <= '0;
      gate_q       <= 1'b0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_len_q   <= gate_len_d;
      delay_q      <= delay_d;
      strobe_len_q <= strobe_len_d;
      rpt_q        <= rpt_d;
      gate_q       <= (state_d == PMC_GATE);
      strobe_q     <= (state_d == PMC_STROBE);
      busy_q       <= (state_d == PMC_GATE) || (state_d == PMC_DELAY) ||
                      (state_d == PMC_STROBE);
      done_q       <= (state_d == PMC_DONE);
    end
  end

  assign pmc_bus.gate   = gate_q;
  assign pmc_bus.strobe = strobe_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule : pmc_gate_strobe_gen

`default_nettype wire

// File: tb/tb_pmc_gate_strobe_gen.sv
// ============================================================================
// Module : tb_pmc_gate_strobe_gen
// Purpose: Directed self-checking bench for pmc_gate_strobe_gen. Each cycle
//          index c starts 1 time unit after a rising edge; outputs of cycle c
//          are compared there, then the inputs for cycle c are driven.
//          Compared vector is {gate, strobe, busy, done}.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pmc_gate_strobe_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] gate_len;
  logic [15:0] strobe_delay;
  logic [15:0] strobe_len;
  logic [7:0]  repeat_cnt;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  soc_pmc_bus bus_if ();

  pmc_gate_strobe_gen #(
    .CNT_WIDTH (16),
    .RPT_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .gate_len     (gate_len),
    .strobe_delay (strobe_delay),
    .strobe_len   (strobe_len),
    .repeat_cnt   (repeat_cnt),
    .pmc_bus      (bus_if),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  wire [3:0] obs = {bus_if.gate, bus_if.strobe, busy, done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] g, input logic [15:0] d,
                         input logic [15:0] s, input logic [7:0] r);
    gate_len     = g;
    strobe_delay = d;
    strobe_len   = s;
    repeat_cnt   = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    step();
    step();
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=0000", obs);
    end
    start = 1'b0;
    rst_n = 1'b1;
    step();
    checks++;
    if (obs !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release got=%b exp=0000", obs);
    end
  endtask

  task automatic test_single();
    logic [3:0] e;
    set_cfg(16'd4, 16'd2, 16'd3, 8'd0);
    for (int c = 0; c <= 12; c++) begin
      e = {(c >= 1 && c <= 4), (c >= 7 && c <= 9), (c >= 1 && c <= 9), (c == 10)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL single c=%0d got=%b exp=%b", c, obs, e);
      end
      start = (c == 0);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_repeat();
    logic [3:0] e;
    logic       run;
    set_cfg(16'd4, 16'd2, 16'd3, 8'd2);
    for (int c = 0; c <= 30; c++) begin
      run = (c >= 1 && c <= 27);
      e = {run && (((c - 1) % 9) < 4), run && (((c - 1) % 9) >= 6), run, (c == 28)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL repeat c=%0d got=%b exp=%b", c, obs, e);
      end
      start = (c == 0);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_zero_phases();
    logic [3:0] e;
    set_cfg(16'd0, 16'd0, 16'd5, 8'd0);
    for (int c = 0; c <= 8; c++) begin
      e = {1'b0, (c >= 1 && c <= 5), (c >= 1 && c <= 5), (c == 6)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL strobe_only c=%0d got=%b exp=%b", c, obs, e);
      end
      start = (c == 0);
      step();
    end
    set_cfg(16'd0, 16'd0, 16'd0, 8'd0);
    for (int c = 0; c <= 4; c++) begin
      e = {1'b0, 1'b0, (c == 1), (c == 2)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL all_zero c=%0d got=%b exp=%b", c, obs, e);
      end
      start = (c == 0);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    // Three dead iterations in a row.
    set_cfg(16'd0, 16'd0, 16'd0, 8'd2);
    for (int c = 0; c <= 6; c++) begin
      e = {1'b0, 1'b0, (c >= 1 && c <= 3), (c == 4)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL dead_repeat c=%0d got=%b exp=%b", c, obs, e);
      end
      start = (c == 0);
      step();
    end
    // Gate and strobe abutting across phases and iterations.
    set_cfg(16'd1, 16'd0, 16'd1, 8'd1);
    for (int c = 0; c <= 7; c++) begin
      e = {(c == 1 || c == 3), (c == 2 || c == 4), (c >= 1 && c <= 4), (c == 5)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abut c=%0d got=%b exp=%b", c, obs, e);
      end
      start = (c == 0);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    logic [3:0] e;
    set_cfg(16'd4, 16'd2, 16'd3, 8'd0);
    for (int c = 0; c <= 18; c++) begin
      e = {(c >= 1 && c <= 3) || (c >= 7 && c <= 10),
           (c >= 13 && c <= 15),
           (c >= 1 && c <= 3) || (c >= 7 && c <= 15),
           (c == 16)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort c=%0d got=%b exp=%b", c, obs, e);
      end
      start = (c == 0 || c == 6);
      abort = (c == 3);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_ignore_start();
    logic [3:0] e;
    int         done_cnt;
    done_cnt = 0;
    set_cfg(16'd4, 16'd2, 16'd3, 8'd0);
    for (int c = 0; c <= 14; c++) begin
      e = {(c >= 1 && c <= 4), (c >= 7 && c <= 9), (c >= 1 && c <= 9), (c == 10)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL ignore_start c=%0d got=%b exp=%b", c, obs, e);
      end
      if (done) done_cnt++;
      start = (c == 0 || c == 2 || c == 10);
      if (c == 2) gate_len = 16'd9;
      step();
    end
    start = 1'b0;
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("FAIL done_pulses got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    set_cfg(16'd4, 16'd2, 16'd3, 8'd0);
    for (int c = 0; c <= 19; c++) begin
      e = {(c >= 1 && c <= 4) || (c >= 8 && c <= 11),
           (c >= 14 && c <= 16),
           (c >= 1 && c <= 5) || (c >= 8 && c <= 16),
           (c == 17)};
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid c=%0d got=%b exp=%b", c, obs, e);
      end
      rst_n = (c != 5);
      start = (c == 0 || c == 7);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_start_abort();
    for (int c = 0; c <= 4; c++) begin
      checks++;
      if (obs !== 4'b0000) begin
        failures++;
        $display("FAIL start_abort c=%0d got=%b exp=0000", c, obs);
      end
      start = (c == 0);
      abort = (c == 0);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_max_len();
    int gate_cnt;
    int overlap;
    int done_at;
    int c;
    gate_cnt = 0;
    overlap  = 0;
    done_at  = -1;
    set_cfg(16'hFFFF, 16'd0, 16'd0, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    while (c < 70000 && done_at < 0) begin
      if (bus_if.gate) gate_cnt++;
      if (bus_if.gate && bus_if.strobe) overlap++;
      if (done) done_at = c;
      step();
      c++;
    end
    checks++;
    if (gate_cnt !== 65535) begin
      failures++;
      $display("FAIL max_gate_cycles got=%0d exp=65535", gate_cnt);
    end
    checks++;
    if (done_at !== 65536) begin
      failures++;
      $display("FAIL max_done_cycle got=%0d exp=65536", done_at);
    end
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL max_overlap got=%0d exp=0", overlap);
    end
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(16'd0, 16'd0, 16'd0, 8'd0);
    test_reset();
    test_single();
    test_repeat();
    test_zero_phases();
    test_back_to_back();
    test_abort();
    test_ignore_start();
    test_reset_mid();
    test_start_abort();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pmc_gate_strobe_gen

`default_nettype wire
